png_idat_pack: RTL and testbench
================================

// Module: png_idat_pack
// PURPOSE
//  Downstream of bs_top: packs its 32-bit zlib word stream into PNG IDAT chunks (length, "IDAT", data, CRC32),
//  then appends the IEND chunk. Buffers up to one chunk of words, emits a byte stream with valid/ready.
//  Output feeds the PNG file writer; the signature/IHDR are emitted ahead of it elsewhere.
// PARAMETERS
//  CHUNK_WORDS  256  max data words per IDAT chunk (1024 bytes); power of two, >=2
//  DATA_WD      32   input word width; fixed at 32
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        synchronous, active-high reset
//  start_i      in   1        pulse: begin new stream; ignored unless IDLE
//  val_i        in   1        input word valid; legal only while rdy_o=1
//  dat_i        in   32       zlib word; byte order [31:24] first
//  lst_i        in   1        with val_i: final word of stream
//  lst_nbyte_i  in   3        with lst_i: valid bytes in final word, 1..4 (0 or >4 treated as 4)
//  rdy_o        out  1        block accepts a word this cycle
//  val_o        out  1        output byte valid
//  dat_o        out  8        output byte
//  rdy_i        in   1        downstream accepts byte (transfer = val_o & rdy_i)
//  lst_o        out  1        with val_o: last byte of IEND
//  done_o       out  1        1-cycle pulse after last IEND byte transfers
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, word count 0, CRC register 0xFFFFFFFF; reset mid-operation discards buffered data.
//  - States: IDLE -start_i-> FILL -chunk closed-> LEN(4B) -> TYPE(4B) -> DATA(n B) -> CRC(4B) -> FILL, or -> IEND(12B) if final -> IDLE.
//  - FILL: rdy_o=1 while count<CHUNK_WORDS; each val_i writes buffer[count], count++.
//  - Chunk closes on the word that makes count==CHUNK_WORDS, or on lst_i; rdy_o drops next cycle; val_o rises next cycle with LEN MSB.
//  - Length = 4*count for full chunks; 4*(count-1)+lst_nbyte for final chunk; sent big-endian.
//  - Words arriving exactly filling the buffer with lst_i: one final chunk then IEND; zero-length IDAT never emitted.
//  - TYPE bytes 49 44 41 54; CRC32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) over TYPE+DATA, sent MSB first.
//  - IEND: 00 00 00 00 49 45 4E 44 AE 42 60 82 (constant, no CRC engine); lst_o on 0x82.
//  - Output holds dat_o/val_o/lst_o stable while val_o & !rdy_i; state advances only on transfer; 1 byte/cycle max.
//  - rdy_o=0 outside FILL; val_i while rdy_o=0 is protocol error: word dropped, sim assertion fires.
//  - CRC register reinitialised on entry to TYPE; count cleared on CRC->FILL.
//  - Buffer read is 1-cycle latency: prefetch next word before DATA byte 3 of current word transfers; no bubbles under rdy_i=1.
//  - start_i during non-IDLE ignored; done_o asserts the cycle after lst_o transfer, state then IDLE.
// STRUCTURE
//  - Shared package: PNG_TYPE_IDAT 32'h49444154, PNG_TYPE_IEND 32'h49454E44, PNG_IEND_CRC 32'hAE426082,
//    CRC32_POLY 32'hEDB88320, CRC32_INIT 32'hFFFFFFFF, state encoding.
//  - Sub-module png_crc32_byte: combinational crc_next = f(crc_cur, byte); register kept in parent.
//  - Buffer: single-port-per-side RAM CHUNK_WORDS x 32, inferred.
// TESTING
//  - CHUNK_WORDS=4; start, words 78DA0102,03040506 lst_nbyte=2 -> 00000006 49444154 78 DA 01 02 03 04 CRC(model) then IEND 12B, done_o.
//  - CHUNK_WORDS=4; 9 words, last lst_nbyte=3 -> IDAT lengths 16,16,3 in order, CRCs match zlib crc32 model, single IEND.
//  - CHUNK_WORDS=4; 8 words, lst_nbyte=4 -> exactly two IDAT of length 16, then IEND; no empty chunk.
//  - Random rdy_i (50% duty) on case 2 -> byte stream identical to rdy_i=1 run; dat_o stable while stalled.
//  - rst asserted mid DATA -> next cycle val_o=rdy_o=done_o=0; new start_i then case 1 reproduces exactly.
//  - val_i pulsed while rdy_o=0 (during LEN) -> word ignored, output unchanged, assertion reported.

Source files
------------

// File: rtl/png_idat_pack_pkg.sv
// Shared constants, state encoding and byte-select helpers for the PNG IDAT/IEND packer.
package png_idat_pack_pkg;

  localparam logic [31:0] PNG_TYPE_IDAT = 32'h49444154;
  localparam logic [31:0] PNG_TYPE_IEND = 32'h49454E44;
  localparam logic [31:0] PNG_IEND_CRC  = 32'hAE426082;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_LEN  = 3'd2,
    ST_TYPE = 3'd3,
    ST_DATA = 3'd4,
    ST_CRC  = 3'd5,
    ST_IEND = 3'd6
  } pk_state_e;

  // Byte sel of a word, big-endian: sel 0 is bits [31:24].
  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      2'd3:    b = w[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Byte k of the fixed 12-byte IEND chunk: zero length, type, CRC.
  function automatic logic [7:0] iend_byte(input logic [3:0] k);
    logic [7:0] b;
    case (k[3:2])
      2'd0:    b = 8'h00;
      2'd1:    b = get_byte(PNG_TYPE_IEND, k[1:0]);
      2'd2:    b = get_byte(PNG_IEND_CRC, k[1:0]);
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/png_idat_pack_if.sv
// Word-in / byte-out handshake bundle of the IDAT packer.
interface png_idat_pack_if;
  logic        start_i;
  logic        val_i;
  logic [31:0] dat_i;
  logic        lst_i;
  logic [2:0]  lst_nbyte_i;
  logic        rdy_o;
  logic        val_o;
  logic [7:0]  dat_o;
  logic        rdy_i;
  logic        lst_o;
  logic        done_o;

  modport slave (
    input  start_i, val_i, dat_i, lst_i, lst_nbyte_i, rdy_i,
    output rdy_o, val_o, dat_o, lst_o, done_o
  );

  modport master (
    output start_i, val_i, dat_i, lst_i, lst_nbyte_i, rdy_i,
    input  rdy_o, val_o, dat_o, lst_o, done_o
  );
endinterface

// File: rtl/png_crc32_byte.sv
// One-byte step of the reflected CRC32 (zlib/PNG); the running register lives in the parent.
module png_crc32_byte
  import png_idat_pack_pkg::*;
(
  input  logic [31:0] crc_cur,
  input  logic [7:0]  dat,
  output logic [31:0] crc_next
);

  logic [31:0] crc_v_s;

  // Eight LSB-first shift/xor steps per byte
  always_comb begin
    crc_v_s = crc_cur ^ {24'h000000, dat};
    for (int i = 0; i < 8; i++) begin
      if (crc_v_s[0]) begin
        crc_v_s = (crc_v_s >> 1) ^ CRC32_POLY;
      end else begin
        crc_v_s = crc_v_s >> 1;
      end
    end
    crc_next = crc_v_s;
  end

endmodule

// File: rtl/png_idat_pack_chk.sv
// Protocol checker: flags words offered while not ready and output changes during a stall.
module png_idat_pack_chk (
  input  logic       clk,
  input  logic       rst,
  input  logic       val_i,
  input  logic       rdy_o,
  input  logic       val_o,
  input  logic       rdy_i,
  input  logic [7:0] dat_o,
  input  logic       lst_o,
  input  logic       allow_err,
  output logic [7:0] err_cnt
);

  logic       prev_stall_r;
  logic [7:0] prev_dat_r;
  logic       prev_lst_r;

  // Count dropped words and remember the stalled output byte
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt      <= 8'd0;
      prev_stall_r <= 1'b0;
      prev_dat_r   <= 8'h00;
      prev_lst_r   <= 1'b0;
    end else begin
      if (val_i && !rdy_o) begin
        err_cnt <= err_cnt + 8'd1;
      end
      prev_stall_r <= val_o && !rdy_i;
      prev_dat_r   <= dat_o;
      prev_lst_r   <= lst_o;
    end
  end

  // Word offered without ready is dropped; only tolerated when the caller expects it
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(val_i && !rdy_o) || allow_err);
      assert (!prev_stall_r || (val_o && dat_o == prev_dat_r && lst_o == prev_lst_r));
    end
  end

endmodule

// File: rtl/png_idat_pack.sv
// Packs a 32-bit zlib word stream into PNG IDAT chunks (len, type, data, CRC32) followed by IEND.
module png_idat_pack
  import png_idat_pack_pkg::*;
#(
  parameter int CHUNK_WORDS = 256,
  parameter int DATA_WD     = 32
) (
  input  logic           clk,
  input  logic           rst,
  png_idat_pack_if.slave bus
);

  localparam int CW_W  = $clog2(CHUNK_WORDS);
  localparam int CNT_W = CW_W + 1;
  localparam int IDX_W = $clog2(4 * CHUNK_WORDS) + 1;

  pk_state_e          state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   len_r;
  logic               final_r;
  logic [31:0]        crc_r;
  logic [DATA_WD-1:0] cur_word_r;
  logic [DATA_WD-1:0] ram_q_r;
  logic [CW_W-1:0]    rd_ptr_r;
  logic [DATA_WD-1:0] mem_r [CHUNK_WORDS];
  logic               rdy_r;
  logic               val_r;
  logic [7:0]         dat_r;
  logic               lst_r;
  logic               done_r;

  logic               wr_en_s;
  logic               close_s;
  logic               xfer_s;
  logic [2:0]         nb_s;
  logic [IDX_W-1:0]   new_len_s;
  logic [IDX_W-1:0]   idx_inc_s;
  logic [31:0]        len32_s;
  logic [31:0]        crc_next_s;
  pk_state_e          nxt_state_s;
  logic [IDX_W-1:0]   nxt_idx_s;
  logic [7:0]         nxt_byte_s;
  logic               nxt_val_s;
  logic               nxt_lst_s;
  logic               nxt_done_s;
  logic               load_word_s;

  assign bus.rdy_o  = rdy_r;
  assign bus.val_o  = val_r;
  assign bus.dat_o  = dat_r;
  assign bus.lst_o  = lst_r;
  assign bus.done_o = done_r;

  assign wr_en_s   = rdy_r & bus.val_i;
  assign close_s   = wr_en_s & (bus.lst_i | (cnt_r == CNT_W'(CHUNK_WORDS - 1)));
  assign xfer_s    = val_r & bus.rdy_i;
  assign nb_s      = ((bus.lst_nbyte_i == 3'd0) || (bus.lst_nbyte_i > 3'd4)) ? 3'd4 : bus.lst_nbyte_i;
  assign new_len_s = bus.lst_i ? ({cnt_r, 2'b00} + {{(IDX_W-3){1'b0}}, nb_s})
                               : IDX_W'(4 * CHUNK_WORDS);
  assign idx_inc_s = idx_r + IDX_W'(1);
  assign len32_s   = 32'(len_r);

  png_crc32_byte u_crc (
    .crc_cur  (crc_r),
    .dat      (dat_r),
    .crc_next (crc_next_s)
  );

  // Chunk buffer: written in FILL, read one cycle after the prefetch pointer moves
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[cnt_r[CW_W-1:0]] <= bus.dat_i;
    end
    ram_q_r <= mem_r[rd_ptr_r];
  end

  // Byte that follows the one currently on dat_o, and where the sequencer goes next
  always_comb begin
    nxt_state_s = state_r;
    nxt_idx_s   = idx_inc_s;
    nxt_byte_s  = 8'h00;
    nxt_val_s   = 1'b1;
    nxt_lst_s   = 1'b0;
    nxt_done_s  = 1'b0;
    load_word_s = 1'b0;
    case (state_r)
      ST_LEN: begin
        if (idx_r == IDX_W'(3)) begin
          nxt_state_s = ST_TYPE;
          nxt_idx_s   = IDX_W'(0);
          nxt_byte_s  = get_byte(PNG_TYPE_IDAT, 2'd0);
        end else begin
          nxt_byte_s  = get_byte(len32_s, idx_inc_s[1:0]);
        end
      end
      ST_TYPE: begin
        if (idx_r == IDX_W'(3)) begin
          nxt_state_s = ST_DATA;
          nxt_idx_s   = IDX_W'(0);
          nxt_byte_s  = get_byte(ram_q_r, 2'd0);
          load_word_s = 1'b1;
        end else begin
          nxt_byte_s  = get_byte(PNG_TYPE_IDAT, idx_inc_s[1:0]);
        end
      end
      ST_DATA: begin
        if (idx_inc_s == len_r) begin
          // dat_r is the last data byte, so the final CRC is this step's result
          nxt_state_s = ST_CRC;
          nxt_idx_s   = IDX_W'(0);
          nxt_byte_s  = get_byte(~crc_next_s, 2'd0);
        end else if (idx_inc_s[1:0] == 2'd0) begin
          nxt_byte_s  = get_byte(ram_q_r, 2'd0);
          load_word_s = 1'b1;
        end else begin
          nxt_byte_s  = get_byte(cur_word_r, idx_inc_s[1:0]);
        end
      end
      ST_CRC: begin
        if (idx_r == IDX_W'(3)) begin
          nxt_idx_s = IDX_W'(0);
          if (final_r) begin
            nxt_state_s = ST_IEND;
            nxt_byte_s  = iend_byte(4'd0);
          end else begin
            nxt_state_s = ST_FILL;
            nxt_val_s   = 1'b0;
          end
        end else begin
          nxt_byte_s = get_byte(~crc_r, idx_inc_s[1:0]);
        end
      end
      ST_IEND: begin
        if (idx_r == IDX_W'(11)) begin
          nxt_state_s = ST_IDLE;
          nxt_idx_s   = IDX_W'(0);
          nxt_val_s   = 1'b0;
          nxt_done_s  = 1'b1;
        end else begin
          nxt_byte_s = iend_byte(idx_inc_s[3:0]);
          nxt_lst_s  = (idx_inc_s == IDX_W'(11));
        end
      end
      default: begin
        nxt_val_s = 1'b0;
      end
    endcase
  end

  // Sequencer: fill, then serialise LEN/TYPE/DATA/CRC and finally IEND
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      idx_r      <= '0;
      len_r      <= '0;
      final_r    <= 1'b0;
      crc_r      <= CRC32_INIT;
      cur_word_r <= '0;
      rd_ptr_r   <= '0;
      rdy_r      <= 1'b0;
      val_r      <= 1'b0;
      dat_r      <= 8'h00;
      lst_r      <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start_i) begin
            state_r <= ST_FILL;
            cnt_r   <= '0;
            final_r <= 1'b0;
            rdy_r   <= 1'b1;
          end
        end
        ST_FILL: begin
          if (wr_en_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
          if (close_s) begin
            state_r <= ST_LEN;
            idx_r   <= '0;
            len_r   <= new_len_s;
            final_r <= bus.lst_i;
            rdy_r   <= 1'b0;
            val_r   <= 1'b1;
            dat_r   <= get_byte(32'(new_len_s), 2'd0);
            lst_r   <= 1'b0;
          end
        end
        default: begin
          if (xfer_s) begin
            state_r <= nxt_state_s;
            idx_r   <= nxt_idx_s;
            dat_r   <= nxt_byte_s;
            val_r   <= nxt_val_s;
            lst_r   <= nxt_lst_s;
            done_r  <= nxt_done_s;
            if (state_r == ST_LEN && nxt_state_s == ST_TYPE) begin
              crc_r    <= CRC32_INIT;
              rd_ptr_r <= '0;
            end else if (state_r == ST_TYPE || state_r == ST_DATA) begin
              crc_r <= crc_next_s;
            end
            if (load_word_s) begin
              cur_word_r <= ram_q_r;
              rd_ptr_r   <= rd_ptr_r + CW_W'(1);
            end
            if (nxt_state_s == ST_FILL) begin
              cnt_r <= '0;
              rdy_r <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_png_idat_pack.sv
// Self-checking bench for png_idat_pack (CHUNK_WORDS=4) against a chunking/CRC32 reference model.
module tb_png_idat_pack;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       allow_err = 1'b0;
  logic [7:0] err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] words_q[$];
  logic [7:0]  got_q[$];
  logic        got_lst_q[$];
  logic [7:0]  exp_q[$];
  logic        exp_lst_q[$];
  int          done_cnt;

  png_idat_pack_if bus ();

  png_idat_pack #(.CHUNK_WORDS(4), .DATA_WD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  png_idat_pack_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .val_i     (bus.val_i),
    .rdy_o     (bus.rdy_o),
    .val_o     (bus.val_o),
    .rdy_i     (bus.rdy_i),
    .dat_o     (bus.dat_o),
    .lst_o     (bus.lst_o),
    .allow_err (allow_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32(input logic [7:0] q[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = (c >> 1) ^ (c[0] ? 32'hEDB88320 : 32'h0);
    end
    return ~c;
  endfunction

  // Reference: flatten the zlib bytes, cut into 16-byte chunks, wrap each, append IEND
  task automatic build_exp(input logic [2:0] nb);
    logic [7:0] flat[$];
    logic [7:0] body[$];
    logic [7:0] iend[12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h49, 8'h45, 8'h4E, 8'h44,
                             8'hAE, 8'h42, 8'h60, 8'h82};
    logic [7:0] idat[4] = '{8'h49, 8'h44, 8'h41, 8'h54};
    int eff = (nb >= 3'd1 && nb <= 3'd4) ? int'(nb) : 4;
    int nw = words_q.size();
    exp_q.delete();
    exp_lst_q.delete();
    for (int w = 0; w < nw; w++)
      for (int b = 0; b < 4; b++)
        if (w < nw - 1 || b < eff) flat.push_back(words_q[w] >> (24 - 8 * b));
    for (int off = 0; off < flat.size(); off += 16) begin
      int len = (flat.size() - off < 16) ? flat.size() - off : 16;
      logic [31:0] c;
      body.delete();
      for (int i = 0; i < 4; i++) body.push_back(idat[i]);
      for (int i = 0; i < len; i++) body.push_back(flat[off + i]);
      c = crc32(body);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(len >> (24 - 8 * i)));
      foreach (body[i]) exp_q.push_back(body[i]);
      for (int i = 0; i < 4; i++) exp_q.push_back(c[31 - 8 * i -: 8]);
    end
    for (int i = 0; i < 12; i++) exp_q.push_back(iend[i]);
    foreach (exp_q[i]) exp_lst_q.push_back(i == exp_q.size() - 1);
  endtask

  // Feed words_q and collect the byte stream, one decision per negedge
  task automatic run_stream(input logic [2:0] nb, input bit rnd_rdy, input int abort_at,
                            input bit inject);
    int wi = 0;
    int cyc = 0;
    bit stalled = 0;
    bit injected = 0;
    bit inj_chk = 0;
    bit finished = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] err_before = 8'h00;
    got_q.delete();
    got_lst_q.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (!finished && cyc < 5000) begin
      allow_err = 1'b0;
      if (stalled) begin
        chk("stall_val", 32'(bus.val_o), 32'd1);
        chk("stall_dat", 32'(bus.dat_o), 32'(held));
      end
      if (inj_chk) begin
        chk("inj_err_cnt", 32'(err_cnt), 32'(err_before + 8'd1));
        chk("inj_rdy", 32'(bus.rdy_o), 32'd0);
        inj_chk = 0;
      end
      bus.val_i = 1'b0;
      bus.lst_i = 1'b0;
      if (bus.rdy_o && wi < words_q.size()) begin
        bus.val_i       = 1'b1;
        bus.dat_i       = words_q[wi];
        bus.lst_i       = (wi == words_q.size() - 1);
        bus.lst_nbyte_i = nb;
        wi++;
      end
      bus.rdy_i = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && !injected && bus.val_o && !bus.rdy_o) begin
        bus.val_i  = 1'b1;
        bus.dat_i  = 32'hDEADBEEF;
        bus.lst_i  = 1'b1;
        bus.rdy_i  = 1'b0;
        allow_err  = 1'b1;
        err_before = err_cnt;
        injected   = 1;
        inj_chk    = 1;
      end
      if (bus.done_o) begin
        done_cnt++;
        finished = 1;
      end
      if (bus.val_o && bus.rdy_i) begin
        got_q.push_back(bus.dat_o);
        got_lst_q.push_back(bus.lst_o);
      end
      stalled = bus.val_o && !bus.rdy_i;
      held = bus.dat_o;
      if (abort_at >= 0 && got_q.size() >= abort_at) finished = 1;
      @(negedge clk);
      cyc++;
    end
    allow_err = 1'b0;
    bus.val_i = 1'b0;
    bus.lst_i = 1'b0;
    bus.rdy_i = 1'b1;
    if (!finished) chk("timeout", 32'd0, 32'd1);
    if (inject) chk("inj_done", 32'(injected), 32'd1);
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      chk($sformatf("%s_l%0d", tag, i), 32'(got_lst_q[i]), 32'(exp_lst_q[i]));
    end
    chk({tag, "_done"}, 32'(done_cnt), 32'd1);
    chk({tag, "_idle_done"}, 32'(bus.done_o), 32'd0);
    chk({tag, "_idle_val"}, 32'(bus.val_o), 32'd0);
    chk({tag, "_idle_rdy"}, 32'(bus.rdy_o), 32'd0);
  endtask

  task automatic set_random_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back($urandom);
  endtask

  initial begin
    logic [7:0] hdr[14] = '{8'h00, 8'h00, 8'h00, 8'h06, 8'h49, 8'h44, 8'h41, 8'h54,
                            8'h78, 8'hDA, 8'h01, 8'h02, 8'h03, 8'h04};
    bus.start_i = 1'b0;
    bus.val_i = 1'b0;
    bus.dat_i = 32'h0;
    bus.lst_i = 1'b0;
    bus.lst_nbyte_i = 3'd4;
    bus.rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 32'(bus.rdy_o), 32'd0);
    chk("rst_val", 32'(bus.val_o), 32'd0);
    chk("rst_dat", 32'(bus.dat_o), 32'd0);
    chk("rst_lst", 32'(bus.lst_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);

    // Directed two-word stream, 6 data bytes
    words_q = '{32'h78DA0102, 32'h03040506};
    build_exp(3'd2);
    run_stream(3'd2, 1'b0, -1, 1'b0);
    compare_stream("case1");
    for (int i = 0; i < 14; i++)
      if (i < got_q.size()) chk($sformatf("case1_hdr%0d", i), 32'(got_q[i]), 32'(hdr[i]));

    // Nine words: chunks of 16, 16, 3 bytes
    set_random_words(9);
    build_exp(3'd3);
    run_stream(3'd3, 1'b0, -1, 1'b0);
    compare_stream("case2");

    // Same stream under random backpressure
    run_stream(3'd3, 1'b1, -1, 1'b0);
    compare_stream("case2_stall");

    // Eight words fill exactly two chunks, no empty third
    set_random_words(8);
    build_exp(3'd4);
    run_stream(3'd4, 1'b0, -1, 1'b0);
    compare_stream("case3");

    // Out-of-range final byte count behaves as 4
    set_random_words(5);
    build_exp(3'd0);
    run_stream(3'd0, 1'b1, -1, 1'b0);
    compare_stream("nb0");

    // Reset while DATA is streaming, then a clean rerun of case 1
    words_q = '{32'h78DA0102, 32'h03040506};
    run_stream(3'd2, 1'b0, 10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_val", 32'(bus.val_o), 32'd0);
    chk("mid_rst_rdy", 32'(bus.rdy_o), 32'd0);
    chk("mid_rst_done", 32'(bus.done_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    build_exp(3'd2);
    run_stream(3'd2, 1'b0, -1, 1'b0);
    compare_stream("after_rst");

    // Word offered during LEN must be dropped
    set_random_words(9);
    build_exp(3'd1);
    run_stream(3'd1, 1'b1, -1, 1'b1);
    compare_stream("inject");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
